// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared RISC-V defines: memory access sizes, widths and LSU state encoding
package _riscv_defines;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_read_size_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        GAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } lsu_state_t;

    // An access is misaligned when its low address bits do not fit its natural alignment.
    function automatic logic is_misaligned(input mem_read_size_t size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_HALF: mis = addr_lo[0];
            MEM_WORD: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - word-addressed data cache port between the LSU (master) and the cache (slave)
interface dcache_if;
    import _riscv_defines::*;

    logic                  req_valid;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] addr;
    mem_read_size_t        size;
    logic                  sign;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  resp_valid;

    modport master (
        output req_valid, write_en, addr, size, sign, write_data,
        input  read_data, resp_valid
    );

    modport slave (
        input  req_valid, write_en, addr, size, sign, write_data,
        output read_data, resp_valid
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction for loads and lane merge for sub-word stores
module lsu_lane_align
    import _riscv_defines::*;
(
    input  logic [DATA_WIDTH-1:0] rd_word_i,
    input  logic [DATA_WIDTH-1:0] base_word_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            lane_i,
    input  mem_read_size_t        size_i,
    input  logic                  sign_i,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic [DATA_WIDTH-1:0] merge_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the read word and extend it to a full register value.
    always_comb begin
        byte_sel    = rd_word_i[{lane_i, 3'b000} +: 8];
        half_sel    = rd_word_i[{lane_i[1], 4'b0000} +: 16];
        load_data_o = rd_word_i;
        case (size_i)
            MEM_BYTE: load_data_o = {{(DATA_WIDTH-8){sign_i & byte_sel[7]}}, byte_sel};
            MEM_HALF: load_data_o = {{(DATA_WIDTH-16){sign_i & half_sel[15]}}, half_sel};
            default:  load_data_o = rd_word_i;
        endcase
    end

    // Replace only the addressed lane of the previously read word; word stores pass straight through.
    always_comb begin
        merge_data_o = base_word_i;
        case (size_i)
            MEM_BYTE: merge_data_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            MEM_HALF: merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default:  merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit with read-modify-write for sub-word stores; optional LSU_MISALIGN_TRAP_EN
module lsu
    import _riscv_defines::*;
#(
    parameter int WORD_IDX_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write_en,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  mem_read_size_t        req_size,
    input  logic                  req_sign,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misalign,
    dcache_if.master              dcache_if
);

    lsu_state_t            state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    mem_read_size_t        size_q;
    logic                  sign_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  dc_req_q;
    logic                  dc_we_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic                  unused_addr_hi;

    // Address bits above the word index never reach the cache.
    assign unused_addr_hi = ^addr_q[ADDR_WIDTH-1:WORD_IDX_W+2];

    lsu_lane_align u_lane_align (
        .rd_word_i    (dcache_if.read_data),
        .base_word_i  (word_q),
        .wdata_i      (wdata_q),
        .lane_i       (addr_q[1:0]),
        .size_i       (size_q),
        .sign_i       (sign_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    assign req_ready            = (state_q == IDLE);
    assign resp_valid           = resp_valid_q;
    assign resp_rdata           = rdata_q;
    assign dcache_if.req_valid  = dc_req_q;
    assign dcache_if.write_en   = dc_we_q;
    assign dcache_if.addr       = ADDR_WIDTH'(addr_q[WORD_IDX_W+1:2]);
    assign dcache_if.size       = size_q;
    assign dcache_if.sign       = sign_q;
    assign dcache_if.write_data = merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign resp_misalign = misalign_q;
`else
    assign resp_misalign = 1'b0;
`endif

    // Access sequencer; cache strobes are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= MEM_BYTE;
            sign_q       <= 1'b0;
            word_q       <= '0;
            dc_req_q     <= 1'b0;
            dc_we_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write_en;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        sign_q  <= req_sign;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_q <= 1'b0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= '0;
                            misalign_q   <= 1'b1;
                        end else
`endif
                        if (req_write_en && (req_size == MEM_WORD)) begin
                            state_q  <= WR;
                            dc_req_q <= 1'b1;
                            dc_we_q  <= 1'b1;
                        end else begin
                            state_q  <= RD;
                            dc_req_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (dcache_if.resp_valid) begin
                        word_q   <= dcache_if.read_data;
                        dc_req_q <= 1'b0;
                        if (write_q) begin
                            state_q <= GAP;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= load_data;
                        end
                    end
                end
                GAP: begin
                    state_q  <= WR;
                    dc_req_q <= 1'b1;
                    dc_we_q  <= 1'b1;
                end
                WR: begin
                    if (dcache_if.resp_valid) begin
                        state_q      <= DONE;
                        dc_req_q     <= 1'b0;
                        dc_we_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= '0;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    dc_req_q <= 1'b0;
                    dc_we_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized scoreboard bench for lsu with a word-memory reference model
module tb_lsu;
    import _riscv_defines::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic           req_write_en;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    mem_read_size_t req_size;
    logic           req_sign;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_misalign;

    dcache_if dc();

    lsu #(.WORD_IDX_W(12)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write_en  (req_write_en),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .req_sign      (req_sign),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .dcache_if     (dc)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
        int          nr;
        int          nw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cmem[4096];
    logic [31:0] ref_mem[4096];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat_override = -1;
    int          c_cnt = 0;
    int          c_lat = 0;
    bit          in_flight = 0;
    bit          cur_store = 0;
    bit          req_seen = 0;
    bit          prev_dresp = 0;
    bit          gap_track = 0;
    int          gap_len = 0;
    int          nr = 0;
    int          nw = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        miscompares++;
        $display("FAIL %s: protocol violation at %0t", name, $time);
    endtask

    // Reference: the addressed field is the size-aligned group of bytes containing addr.
    function automatic exp_t model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                   input mem_read_size_t sz, input bit sg);
        exp_t   e;
        int     idx;
        int     nbytes;
        int     off;
        longint w;
        longint mask;
        longint v;
        idx    = int'(a[13:2]);
        nbytes = (sz == MEM_BYTE) ? 1 : ((sz == MEM_HALF) ? 2 : 4);
        off    = (int'(a[1:0]) / nbytes) * nbytes;
        w      = longint'(ref_mem[idx]);
        mask   = (longint'(1) << (8 * nbytes)) - 1;
        v      = (w >> (8 * off)) & mask;
        e.mis  = TRAP && ((int'(a[1:0]) % nbytes) != 0);
        e.rdata = '0;
        e.nr = 0;
        e.nw = 0;
        if (!e.mis) begin
            if (!we) begin
                if (sg && (v >= (mask + 1) / 2)) v = v - (mask + 1);
                e.rdata = v[31:0];
                e.nr = 1;
            end else begin
                e.nw = 1;
                e.nr = (nbytes == 4) ? 0 : 1;
                w = (w & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
                ref_mem[idx] = w[31:0];
            end
        end
        return e;
    endfunction

    // Cache model: random latency per access, reloaded whenever req_valid is low.
    always @(posedge clk) begin
        if (!rst_n || !dc.req_valid) begin
            c_cnt         <= 0;
            dc.resp_valid <= 1'b0;
            c_lat         <= (lat_override >= 0) ? lat_override : int'($urandom_range(0, 3));
        end else if (dc.resp_valid) begin
            dc.resp_valid <= 1'b0;
        end else if (c_cnt >= c_lat) begin
            dc.resp_valid <= 1'b1;
            dc.read_data  <= cmem[dc.addr[11:0]];
            if (dc.write_en) cmem[dc.addr[11:0]] <= dc.write_data;
        end else begin
            c_cnt <= c_cnt + 1;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each completion.
    always @(negedge clk) begin
        if (prev_dresp && dc.req_valid === 1'b1) flag("dc_req_after_resp");
        if (dc.write_en === 1'b1 && dc.req_valid !== 1'b1) flag("dc_we_without_req");
        if (in_flight && req_ready === 1'b1) flag("req_ready_while_busy");
        if (dc.req_valid === 1'b1) req_seen = 1'b1;
        if (gap_track) begin
            if (dc.req_valid === 1'b1) begin
                chk("gap_cycles", 32'(gap_len), 32'd1);
                gap_track = 1'b0;
            end else begin
                gap_len++;
            end
        end
        if (dc.resp_valid === 1'b1) begin
            if (dc.write_en === 1'b1) nw++;
            else begin
                nr++;
                if (cur_store) begin
                    gap_track = 1'b1;
                    gap_len   = 0;
                end
            end
        end
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                flag("unexpected_resp");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_misalign", 32'(resp_misalign), 32'(e.mis));
                chk("cache_reads", 32'(nr), 32'(e.nr));
                chk("cache_writes", 32'(nw), 32'(e.nw));
                if (e.mis) chk("trap_no_dc_req", 32'(req_seen), 32'd0);
            end
            last_rdata = resp_rdata;
            in_flight  = 1'b0;
        end
        prev_dresp = (dc.resp_valid === 1'b1);
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                req_valid = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        chk("idle_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input mem_read_size_t sz, input bit sg, input bit push);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        req_write_en = we;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_sign     = sg;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        if (push) sb.push_back(model(we, a, wd, sz, sg));
        in_flight = 1'b1;
        cur_store = we;
        req_seen  = 1'b0;
        nr = 0;
        nw = 0;
        // Junk while busy must be ignored.
        req_valid    = 1'($urandom_range(0, 1));
        req_write_en = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic drain(input string name, input logic [31:0] exp);
        bit ok;
        wait_idle(ok);
        chk(name, last_rdata, exp);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 4096; i++) begin
            cmem[i]    = (i < 16) ? $urandom : 32'h0;
            ref_mem[i] = cmem[i];
        end
        cmem[1]    = 32'h8000_80F0;
        ref_mem[1] = 32'h8000_80F0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write_en = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_size = MEM_BYTE;
        req_sign = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_misalign", 32'(resp_misalign), 32'd0);
        chk("rst_dc_req_valid", 32'(dc.req_valid), 32'd0);
        chk("rst_dc_write_en", 32'(dc.write_en), 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 32'h4, 32'h0, MEM_BYTE, 1'b1, 1'b1);
        drain("sbyte_0x4", 32'hFFFF_FFF0);
        issue(1'b0, 32'h5, 32'h0, MEM_BYTE, 1'b0, 1'b1);
        drain("ubyte_0x5", 32'h0000_0080);
        issue(1'b0, 32'h6, 32'h0, MEM_HALF, 1'b1, 1'b1);
        drain("shalf_0x6", 32'hFFFF_8000);
        issue(1'b0, 32'h6, 32'h0, MEM_HALF, 1'b0, 1'b1);
        drain("uhalf_0x6", 32'h0000_8000);
        issue(1'b1, 32'h7, 32'h0000_00AB, MEM_BYTE, 1'b0, 1'b1);
        drain("sb_rdata", 32'h0);
        chk("sb_mem_word1", cmem[1], 32'hAB00_80F0);
        issue(1'b0, 32'h4, 32'h0, MEM_WORD, 1'b0, 1'b1);
        drain("lw_after_sb", 32'hAB00_80F0);
        issue(1'b1, 32'h8, 32'h1234_5678, MEM_WORD, 1'b0, 1'b1);
        drain("sw_rdata", 32'h0);
        chk("sw_mem_word2", cmem[2], 32'h1234_5678);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 32'h6, 32'h0, MEM_WORD, 1'b0, 1'b1);
        @(negedge clk);
        chk("trap_resp_valid", 32'(resp_valid), 32'd1);
        chk("trap_resp_misalign", 32'(resp_misalign), 32'd1);
        drain("trap_rdata", 32'h0);
`endif

        // Reset in the middle of a read: the access is abandoned silently.
        lat_override = 6;
        issue(1'b0, 32'h4, 32'h0, MEM_WORD, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (dc.req_valid === 1'b1) ok = 1'b1;
        end
        chk("abort_reached_rd", 32'(ok), 32'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        in_flight = 1'b0;
        gap_track = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_dc_req_valid", 32'(dc.req_valid), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        lat_override = -1;

        for (int n = 0; n < 250; n++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                  mem_read_size_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle(ok);
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", cmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter WORD_IDX_W, default 12, giving the width of the word index driven to the data cache.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit, a pipeline memory request.
REQ-005 SHALL have port req_ready, output, 1 bit, high when the LSU can accept a request.
REQ-006 SHALL have port req_write_en, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, ADDR_WIDTH bits, the byte address.
REQ-008 SHALL have port req_wdata, input, DATA_WIDTH bits, the store data (right-aligned).
REQ-009 SHALL have port req_size, input, mem_read_size_t, selecting byte, half or word.
REQ-010 SHALL have port req_sign, input, 1 bit: 1 = sign-extend loads.
REQ-011 SHALL have port resp_valid, output, 1 bit, a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, DATA_WIDTH bits, the extended load data.
REQ-013 SHALL have port resp_misalign, output, 1 bit, a misaligned-access flag valid with resp_valid.
REQ-014 SHALL have port dcache_if, dcache_if.master, the word-addressed data cache port.

Function
REQ-015 SHALL accept a request on req_valid && req_ready and capture all req_* fields into registers.
- req_ready = 1 only in state IDLE.
REQ-016 SHALL implement states IDLE, RD, GAP, WR and DONE.
- Load: IDLE->RD->DONE.
- Word store: IDLE->WR->DONE.
- Byte/half store: IDLE->RD->GAP->WR->DONE (read-modify-write).
- DONE->IDLE always.
REQ-017 SHALL drive dcache_if.req_valid = 1 exactly in RD and WR, and dcache_if.write_en = 1 only in WR.
REQ-018 SHALL leave RD and WR only on the cycle dcache_if.resp_valid is sampled 1, so req_valid is low the following cycle.
- Any cache latency SHALL be tolerated.
REQ-019 SHALL hold GAP for exactly one cycle with req_valid low, so the cache latency counter reloads between read and write.
REQ-020 SHALL drive dcache_if.addr = zero-extended captured addr[WORD_IDX_W+1:2].
- dcache_if.size and dcache_if.sign SHALL carry the captured values.
REQ-021 SHALL capture dcache_if.read_data in RD on the resp_valid cycle into an internal word register.
REQ-022 SHALL extract load data as follows:
- Byte: lane addr[1:0], bits [8k+7:8k].
- Half: lane addr[1], bits [16h+15:16h].
- Word: the whole word.
- Result sign-extended if captured sign = 1, else zero-extended.
REQ-023 SHALL drive dcache_if.write_data in WR as follows:
- Word store: req_wdata.
- Byte/half store: the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
REQ-024 SHALL pulse resp_valid for exactly one cycle in DONE.
- resp_rdata SHALL be valid in that cycle and held until the next DONE.
- resp_rdata SHALL be 0 for stores.
REQ-025 SHALL ignore req_valid while not in IDLE; there is no queueing.

Reset
REQ-026 SHALL, when rst_n = 0 at a clock edge, force:
- state IDLE;
- resp_valid = 0, resp_rdata = 0 and resp_misalign = 0;
- captured registers 0;
- dcache_if.req_valid and dcache_if.write_en = 0 from the next cycle.
REQ-027 SHALL, on reset mid-operation (RD/GAP/WR), abandon the access with no resp_valid pulse; a partially completed RMW write is not retried.

Configuration
REQ-028 SHALL support the macro LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, goes IDLE->DONE with no cache access, resp_misalign = 1 and resp_rdata = 0.
- Undefined: resp_misalign is tied 0, and low address bits not used for lane selection are ignored.

Structure
REQ-029 SHALL place the lsu_state_t enum in the shared package _riscv_defines; mem_read_size_t, ADDR_WIDTH and DATA_WIDTH already come from that package.
REQ-030 SHALL place the combinational lane extract/merge in a sub-module named lsu_lane_align.

Verification
REQ-031 SHALL pass: cache word 1 = 0x8000_80F0; signed byte load at 0x4 -> resp_rdata 0xFFFF_FFF0; unsigned byte load at 0x5 -> 0x0000_0080.
REQ-032 SHALL pass: signed half load at 0x6 on that word -> 0xFFFF_8000; unsigned half load -> 0x0000_8000.
REQ-033 SHALL pass: byte store 0xAB at 0x7 -> RD, then one GAP cycle with req_valid = 0, then WR writing 0xAB00_80F0; a word load at 0x4 then returns 0xAB00_80F0.
REQ-034 SHALL pass: word store 0x1234_5678 at 0x8 -> no RD state; cache word 2 = 0x1234_5678; resp_valid exactly one pulse; req_ready low throughout.
REQ-035 SHALL pass, with LSU_MISALIGN_TRAP_EN: word load at 0x6 -> resp_valid and resp_misalign = 1 one cycle after accept, dcache_if.req_valid never asserted.
REQ-036 SHALL pass: rst_n = 0 for one cycle during RD -> next cycle state IDLE, req_ready = 1, dcache_if.req_valid = 0, no resp_valid.
